// File: rtl/one_rv32_pkg.sv
// Shared definitions for the one_rv32 codebase: arbitration mode
// encodings and a width helper used wherever an index must be at
// least one bit wide.
package one_rv32_pkg;

  // Arbitration policies understood by rr_arbiter and its users.
  localparam int ARB_RR    = 0;  // round-robin starting at a rotating pointer
  localparam int ARB_FIXED = 1;  // lowest index always wins

  // $clog2 that never returns 0, so a one-channel mux still gets a
  // real (constant-zero) select signal instead of a zero-width vector.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational N-way arbiter. In round-robin mode the search
// starts at ptr and wraps modulo N_CH; in fixed mode it always starts at
// index 0 and ptr is ignored. Kept free of state so the bus interconnect
// can reuse it with its own pointer policy.
module rr_arbiter
  import one_rv32_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int ARB_MODE = ARB_RR,
  parameter int SEL_W    = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any
);

  // Scan N_CH candidates in priority order and keep the first requester.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that
    // leaves one unassigned would infer a latch.
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      int idx;
      // Modulo keeps the wrap correct for non-power-of-two N_CH, where
      // ptr + k can exceed N_CH-1 without overflowing SEL_W bits.
      idx = (ARB_MODE == ARB_FIXED) ? k : ((int'(ptr) + k) % N_CH);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/muxn_rr_reg.sv
// N-channel valid/ready mux with a single registered output stage.
// Merges several producers onto one consumer (e.g. instruction fetch and
// data requests onto the single memory port) at one word per cycle.
// The grant is recomputed every cycle from in_valid and the rotating
// pointer; nothing about a pending grant is remembered across a stall.
module muxn_rr_reg
  import one_rv32_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_CH       = 4,
  parameter int ARB_MODE   = ARB_RR,
  localparam int SEL_W     = clog2_min1(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            in_valid,
  input  logic [N_CH*DATA_WIDTH-1:0] in_data,
  output logic [N_CH-1:0]            in_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]           out_sel,
  input  logic                       out_ready
);

  // Last channel index expressed at select width, used for the wrap.
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] ptr;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_any;
  logic             load_en;
  logic             accept;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [SEL_W-1:0] ptr_next;

  rr_arbiter #(
    .N_CH     (N_CH),
    .ARB_MODE (ARB_MODE),
    .SEL_W    (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // The output register can take a word when it is empty or being drained
  // this cycle. Reset suppresses every handshake so no transfer counts in
  // a reset cycle.
  always_comb begin
    load_en  = !out_valid || out_ready;
    in_ready = grant & {N_CH{load_en && !rst}};
    accept   = grant_any && load_en && !rst;
  end

  // Payload select via indexed part-select on the granted channel, and the
  // pointer advance that wraps from the last channel back to 0.
  always_comb begin
    sel_data = in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    ptr_next = (grant_idx == LAST_CH) ? '0 : grant_idx + SEL_W'(1);
  end

  // Output register and round-robin pointer. A drain with no new word
  // empties the register; a drain with an accept replaces the word.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the payload register is reset too, not just the valid flag,
      // so out_data reads a defined 0 after reset.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
      if (ARB_MODE == ARB_RR) begin
        ptr <= ptr_next;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Self-checking bench for muxn_rr_reg (N_CH=4, DATA_WIDTH=32). One
// round-robin and one fixed-priority instance share the stimulus; a
// reference model predicts each grant and pushes the expected word onto a
// scoreboard queue, which is popped as the active instance drains words.
module tb_muxn_rr_reg;
  import one_rv32_pkg::*;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam int SW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] in_valid;
  logic [NC*DW-1:0] in_data;
  logic          out_ready;

  logic [NC-1:0] rr_in_ready, fx_in_ready;
  logic          rr_out_valid, fx_out_valid;
  logic [DW-1:0] rr_out_data, fx_out_data;
  logic [SW-1:0] rr_out_sel, fx_out_sel;

  beat_t sb[$];
  int    obs_sel[$];
  int    mode;
  int    m_ptr;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  muxn_rr_reg #(.DATA_WIDTH(DW), .N_CH(NC), .ARB_MODE(ARB_RR)) dut_rr (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rr_in_ready),
    .out_valid (rr_out_valid),
    .out_data  (rr_out_data),
    .out_sel   (rr_out_sel),
    .out_ready (out_ready)
  );

  muxn_rr_reg #(.DATA_WIDTH(DW), .N_CH(NC), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (fx_in_ready),
    .out_valid (fx_out_valid),
    .out_data  (fx_out_data),
    .out_sel   (fx_out_sel),
    .out_ready (out_ready)
  );

  function automatic logic [NC-1:0] cur_in_ready();
    return (mode == ARB_FIXED) ? fx_in_ready : rr_in_ready;
  endfunction
  function automatic logic cur_out_valid();
    return (mode == ARB_FIXED) ? fx_out_valid : rr_out_valid;
  endfunction
  function automatic logic [DW-1:0] cur_out_data();
    return (mode == ARB_FIXED) ? fx_out_data : rr_out_data;
  endfunction
  function automatic logic [SW-1:0] cur_out_sel();
    return (mode == ARB_FIXED) ? fx_out_sel : rr_out_sel;
  endfunction

  // Distinct payload per channel and per cycle.
  task automatic set_data(input int seed);
    for (int i = 0; i < NC; i++) begin
      in_data[i*DW +: DW] = 32'hC000_0000 + (seed << 4) + i;
    end
  endtask

  // Reset both instances and the model without comparing anything.
  task automatic reset_all();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_ptr = 0;
  endtask

  // One clock of the reference model: compare at the negedge, then
  // advance the model past the rising edge.
  task automatic step();
    logic [NC-1:0] exp_ready;
    int            g;
    bit            m_valid;
    bit            load_en;
    beat_t         b;
    @(negedge clk);
    m_valid = (sb.size() != 0);
    load_en = !m_valid || out_ready;
    g = -1;
    for (int k = 0; k < NC; k++) begin
      int idx;
      idx = (mode == ARB_FIXED) ? k : ((m_ptr + k) % NC);
      if (g < 0 && in_valid[idx]) g = idx;
    end
    exp_ready = '0;
    if (g >= 0 && load_en && !rst) exp_ready[g] = 1'b1;
    checks++;
    if (cur_in_ready() !== exp_ready) begin
      errors++;
      $display("FAIL model_in_ready: got %b expected %b", cur_in_ready(), exp_ready);
    end
    checks++;
    if (cur_out_valid() !== m_valid) begin
      errors++;
      $display("FAIL model_out_valid: got %b expected %b", cur_out_valid(), m_valid);
    end
    if (m_valid) begin
      checks++;
      if (cur_out_data() !== sb[0].data || cur_out_sel() !== sb[0].sel) begin
        errors++;
        $display("FAIL model_out_word: got data=%h sel=%0d expected data=%h sel=%0d",
                 cur_out_data(), cur_out_sel(), sb[0].data, sb[0].sel);
      end
      if (out_ready && !rst) obs_sel.push_back(int'(cur_out_sel()));
    end
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      m_ptr = 0;
    end else begin
      if (m_valid && out_ready) void'(sb.pop_front());
      if (exp_ready != '0) begin
        b.data = in_data[g*DW +: DW];
        b.sel  = SW'(g);
        sb.push_back(b);
        if (mode == ARB_RR) m_ptr = (g + 1) % NC;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (rr_out_valid !== 1'b0 || rr_out_data !== '0 || rr_out_sel !== '0) begin
      errors++;
      $display("FAIL reset_rr: got v=%b d=%h s=%0d expected 0/0/0", rr_out_valid, rr_out_data, rr_out_sel);
    end
    checks++;
    if (fx_out_valid !== 1'b0 || fx_out_data !== '0 || fx_out_sel !== '0) begin
      errors++;
      $display("FAIL reset_fx: got v=%b d=%h s=%0d expected 0/0/0", fx_out_valid, fx_out_data, fx_out_sel);
    end
  endtask

  task automatic test_single();
    mode = ARB_RR;
    reset_all();
    set_data(1);
    in_data[0 +: DW] = 32'hA;
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    #1;
    checks++;
    if (rr_in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_in_ready: got %b expected 0001", rr_in_ready);
    end
    step();
    in_valid = 4'b0000;
    checks++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 32'hA || rr_out_sel !== 2'd0) begin
      errors++;
      $display("FAIL single_out: got v=%b d=%h s=%0d expected 1/0000000a/0",
               rr_out_valid, rr_out_data, rr_out_sel);
    end
    step();
  endtask

  task automatic test_rr_fairness();
    mode = ARB_RR;
    reset_all();
    obs_sel.delete();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      set_data(c + 16);
      step();
    end
    in_valid = 4'b0000;
    checks++;
    if (obs_sel.size() != 8) begin
      errors++;
      $display("FAIL rr_count: got %0d beats expected 8", obs_sel.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_sel[i] != i % NC) begin
          errors++;
          $display("FAIL rr_seq[%0d]: got %0d expected %0d", i, obs_sel[i], i % NC);
        end
      end
    end
    step();
  endtask

  task automatic test_fixed();
    mode = ARB_FIXED;
    reset_all();
    obs_sel.delete();
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      set_data(c + 32);
      step();
      checks++;
      if (fx_in_ready[3] !== 1'b0) begin
        errors++;
        $display("FAIL fixed_ch3: got in_ready=%b expected bit3 clear", fx_in_ready);
      end
    end
    in_valid = 4'b0000;
    checks++;
    if (obs_sel.size() != 6) begin
      errors++;
      $display("FAIL fixed_count: got %0d beats expected 6", obs_sel.size());
    end
    foreach (obs_sel[i]) begin
      checks++;
      if (obs_sel[i] != 1) begin
        errors++;
        $display("FAIL fixed_sel[%0d]: got %0d expected 1", i, obs_sel[i]);
      end
    end
    step();
    mode = ARB_RR;
  endtask

  task automatic test_stall();
    mode = ARB_RR;
    reset_all();
    set_data(48);
    in_data[0 +: DW] = 32'h11;
    in_data[2*DW +: DW] = 32'h22;
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    step();
    in_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (rr_in_ready !== 4'b0000 || rr_out_valid !== 1'b1 ||
          rr_out_data !== 32'h11 || rr_out_sel !== 2'd0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got rdy=%b v=%b d=%h s=%0d expected 0000/1/00000011/0",
                 c, rr_in_ready, rr_out_valid, rr_out_data, rr_out_sel);
      end
    end
    out_ready = 1'b1;
    step();
    in_valid = 4'b0000;
    checks++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 32'h22 || rr_out_sel !== 2'd2) begin
      errors++;
      $display("FAIL stall_replace: got v=%b d=%h s=%0d expected 1/00000022/2",
               rr_out_valid, rr_out_data, rr_out_sel);
    end
    step();
  endtask

  task automatic test_wrap();
    mode = ARB_RR;
    reset_all();
    set_data(64);
    out_ready = 1'b1;
    in_valid  = 4'b0100;
    step();
    in_valid = 4'b1000;
    #1;
    checks++;
    if (rr_in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_ch3: got %b expected 1000", rr_in_ready);
    end
    step();
    in_valid = 4'b1001;
    #1;
    checks++;
    if (rr_in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_to0: got %b expected 0001", rr_in_ready);
    end
    step();
    in_valid = 4'b0000;
    step();
  endtask

  task automatic test_back_to_back_reset();
    mode = ARB_RR;
    reset_all();
    set_data(80);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (rr_in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_in_ready: got %b expected 0000", rr_in_ready);
    end
    step();
    rst = 1'b0;
    checks++;
    if (rr_out_valid !== 1'b0 || rr_out_sel !== 2'd0) begin
      errors++;
      $display("FAIL rst_drop: got v=%b s=%0d expected 0/0", rr_out_valid, rr_out_sel);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (rr_in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_first_grant: got %b expected 0001", rr_in_ready);
    end
    step();
    step();
    in_valid = 4'b0000;
    step();
    step();
  endtask

  initial begin
    mode      = ARB_RR;
    m_ptr     = 0;
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single();
    test_rr_fairness();
    test_fixed();
    test_stall();
    test_wrap();
    test_back_to_back_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
